// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: flush FSM states,
// address-width helper and the byte-lane merge used by both write and bypass paths.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } flush_state_e;

    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operates at the widest supported width; callers extend and truncate.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_v,
        input logic [MAX_DATA_W-1:0] new_v,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] r;
        r = old_v;
        for (int unsigned b = 0; b < MAX_BE_W; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-result bits for registers awaiting a multi-cycle result; a reservation
// beats a same-cycle clear, and register 0 can be held permanently not-pending.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = addr_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    input  logic                 flush_en,
    input  logic [AW-1:0]        flush_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_pend
);

    logic [NUM_REGS-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (flush_en) pend_d[flush_addr] = 1'b0;
        if (clr_en)   pend_d[clr_addr]   = 1'b0;
        if (set_en)   pend_d[set_addr]   = 1'b1;
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    always_comb begin
        rd_pend = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            rd_pend[k] = pend_q[a] && !((ZERO_REG != 0) && (a == '0));
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with write bypass, byte enables,
// pending-result scoreboard and a sequenced one-register-per-cycle flush.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned NUM_REGS = 32,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned BYPASS   = 1,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = addr_w(NUM_REGS),
    localparam int unsigned BE_W     = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [BE_W-1:0]          wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [BE_W-1:0]   be
    );
        return DATA_W'(byte_merge(MAX_DATA_W'(old_v), MAX_DATA_W'(new_v), MAX_BE_W'(be)));
    endfunction

    flush_state_e                    state_q;
    logic [AW-1:0]                   cnt_q;
    logic                            clr_busy_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                            idle;
    logic                            wr_zero;
    logic                            wr_eff;
    logic                            rsv_eff;
    logic [DATA_W-1:0]               wr_merged;
    logic [NUM_RD-1:0]               pend_rd;

    assign idle      = (state_q == IDLE);
    assign wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_eff    = wr_en && idle && !wr_zero;
    assign rsv_eff   = rsv_en && idle;
    assign wr_merged = merge(regs_q[wr_addr], wr_data, wr_be);
    assign clr_busy  = clr_busy_q;

    always_comb begin
        regs_d = regs_q;
        if (!idle)       regs_d[cnt_q]   = '0;
        else if (wr_eff) regs_d[wr_addr] = wr_merged;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (clr_req) begin
                        state_q    <= CLEAR;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (rsv_eff),
        .set_addr   (rsv_addr),
        .clr_en     (wr_en && idle),
        .clr_addr   (wr_addr),
        .flush_en   (!idle),
        .flush_addr (cnt_q),
        .rd_addr    (rd_addr),
        .rd_pend    (pend_rd)
    );

    // Bypass only forwards writes that will actually land, so nothing leaks during a flush.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            logic [AW-1:0] a;
            logic          zero_k;
            logic          hit_k;
            a      = rd_addr[k*AW +: AW];
            zero_k = (ZERO_REG != 0) && (a == '0);
            hit_k  = (BYPASS != 0) && wr_eff && (wr_addr == a);
            if (zero_k)     rd_data[k*DATA_W +: DATA_W] = '0;
            else if (hit_k) rd_data[k*DATA_W +: DATA_W] = wr_merged;
            else            rd_data[k*DATA_W +: DATA_W] = regs_q[a];
            rd_busy[k] = pend_rd[k] && !hit_k;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: vector table for read/write/bypass/scoreboard
// behaviour plus hand sequences for the flush and reset-during-flush cases.
module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]    rd_busy, rd_busy_nb;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW/8-1:0]   wr_be;
    logic [DW-1:0]     wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              clr_req;
    logic              clr_busy, clr_busy_nb;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_busy(clr_busy)
    );

    reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_busy(clr_busy_nb)
    );

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [3:0]  wr_be;
        logic [31:0] wr_data;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e_d0;
        logic        e_b0;
        logic [31:0] e_d1;
        logic        e_b1;
        logic [31:0] e_nb_d0;
        logic        e_nb_b0;
    } vec_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   errs     = 0;
    int   n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_act(input int sel);
        case (sel)
            0:       return rd_data[31:0];
            1:       return 32'(rd_busy[0]);
            2:       return rd_data[63:32];
            3:       return 32'(rd_busy[1]);
            4:       return rd_data_nb[31:0];
            5:       return 32'(rd_busy_nb[0]);
            6:       return 32'(clr_busy);
            7:       return 32'(clr_busy_nb);
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, get_act(e.sel), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_be    = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        clr_req  = 1'b0;
    endtask

    vec_t vecs[17];
    int   cycles;

    initial begin
        //           we    wa     be     wdata          rsv   ra     a0     a1     e_d0           b0    e_d1           b1    nb_d0          nb_b0
        vecs[0]  = '{1'b1, 5'd5,  4'hF,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  4'hF,  32'h00001234, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 5'd7,  4'hF,  32'h11223344, 1'b0, 5'd0,  5'd0,  5'd5,  32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 5'd7,  4'h3,  32'hAABBCCDD, 1'b0, 5'd0,  5'd7,  5'd7,  32'h1122CCDD, 1'b0, 32'h1122CCDD, 1'b0, 32'h11223344, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  4'h0,  32'h00000000, 1'b1, 5'd9,  5'd9,  5'd7,  32'h00000000, 1'b0, 32'h1122CCDD, 1'b0, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  4'h0,  32'h00000000, 1'b0, 5'd0,  5'd9,  5'd7,  32'h00000000, 1'b1, 32'h1122CCDD, 1'b0, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  4'h0,  32'h00000000, 1'b0, 5'd0,  5'd9,  5'd7,  32'h00000000, 1'b1, 32'h1122CCDD, 1'b0, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 5'd9,  4'hF,  32'h00000055, 1'b0, 5'd0,  5'd9,  5'd9,  32'h00000055, 1'b0, 32'h00000055, 1'b0, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, 5'd0,  4'h0,  32'h00000000, 1'b0, 5'd0,  5'd9,  5'd5,  32'h00000055, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000055, 1'b0};
        vecs[9]  = '{1'b1, 5'd3,  4'hF,  32'hCAFEF00D, 1'b1, 5'd3,  5'd3,  5'd9,  32'hCAFEF00D, 1'b0, 32'h00000055, 1'b0, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 5'd0,  4'h0,  32'h00000000, 1'b0, 5'd0,  5'd3,  5'd0,  32'hCAFEF00D, 1'b1, 32'h00000000, 1'b0, 32'hCAFEF00D, 1'b1};
        vecs[11] = '{1'b1, 5'd0,  4'hF,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd3,  32'h00000000, 1'b0, 32'hCAFEF00D, 1'b1, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  4'h0,  32'h00000000, 1'b0, 5'd0,  5'd0,  5'd3,  32'h00000000, 1'b0, 32'hCAFEF00D, 1'b1, 32'h00000000, 1'b0};
        vecs[13] = '{1'b1, 5'd12, 4'hA,  32'h12345678, 1'b0, 5'd0,  5'd12, 5'd0,  32'h12005600, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[14] = '{1'b1, 5'd12, 4'h0,  32'hFFFFFFFF, 1'b1, 5'd12, 5'd12, 5'd12, 32'h12005600, 1'b0, 32'h12005600, 1'b0, 32'h12005600, 1'b0};
        vecs[15] = '{1'b1, 5'd3,  4'hF,  32'h00000000, 1'b0, 5'd0,  5'd12, 5'd3,  32'h12005600, 1'b1, 32'h00000000, 1'b0, 32'h12005600, 1'b1};
        vecs[16] = '{1'b0, 5'd0,  4'h0,  32'h00000000, 1'b0, 5'd0,  5'd3,  5'd12, 32'h00000000, 1'b0, 32'h12005600, 1'b1, 32'h00000000, 1'b0};

        idle_inputs();
        rd_addr = {5'd7, 5'd5};
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        expect_v("rst_d0", 0, 32'h0);
        expect_v("rst_d1", 2, 32'h0);
        expect_v("rst_b0", 1, 32'h0);
        expect_v("rst_b1", 3, 32'h0);
        expect_v("rst_clr_busy", 6, 32'h0);
        drain();

        for (int i = 0; i < 17; i++) begin
            wr_en    = vecs[i].wr_en;
            wr_addr  = vecs[i].wr_addr;
            wr_be    = vecs[i].wr_be;
            wr_data  = vecs[i].wr_data;
            rsv_en   = vecs[i].rsv_en;
            rsv_addr = vecs[i].rsv_addr;
            rd_addr  = {vecs[i].a1, vecs[i].a0};
            expect_v($sformatf("v%0d_d0", i), 0, vecs[i].e_d0);
            expect_v($sformatf("v%0d_b0", i), 1, 32'(vecs[i].e_b0));
            expect_v($sformatf("v%0d_d1", i), 2, vecs[i].e_d1);
            expect_v($sformatf("v%0d_b1", i), 3, 32'(vecs[i].e_b1));
            expect_v($sformatf("v%0d_nb_d0", i), 4, vecs[i].e_nb_d0);
            expect_v($sformatf("v%0d_nb_b0", i), 5, 32'(vecs[i].e_nb_b0));
            #1;
            drain();
            step();
        end
        idle_inputs();

        // Full flush: fill every register, reserve r21, then clear.
        for (int i = 0; i < NR; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_be   = 4'hF;
            wr_data = 32'hA500_0000 | 32'(i);
            step();
        end
        idle_inputs();
        rsv_en   = 1'b1;
        rsv_addr = 5'd21;
        step();
        idle_inputs();
        rd_addr = {5'd21, 5'd20};
        #1;
        expect_v("fill_r20", 0, 32'hA500_0014);
        expect_v("fill_b21", 3, 32'h1);
        drain();

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        expect_v("flush_rise", 6, 32'h1);
        drain();
        cycles = 0;
        while (clr_busy === 1'b1 && cycles < 100) begin
            if (cycles == 10) begin
                wr_en    = 1'b1;
                wr_addr  = 5'd2;
                wr_be    = 4'hF;
                wr_data  = 32'hFFFF_FFFF;
                rsv_en   = 1'b1;
                rsv_addr = 5'd2;
                clr_req  = 1'b1;
                rd_addr  = {5'd20, 5'd2};
                #1;
                expect_v("mid_r2_nobypass", 0, 32'h0);
                expect_v("mid_b2", 1, 32'h0);
                expect_v("mid_r20_live", 2, 32'hA500_0014);
                drain();
            end
            step();
            idle_inputs();
            cycles++;
        end
        check("flush_len", 32'(cycles), 32'd32);
        expect_v("flush_nb_done", 7, 32'h0);
        drain();
        for (int a = 0; a < NR; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            expect_v($sformatf("post_flush_r%0d", a), 0, 32'h0);
            expect_v($sformatf("post_flush_b%0d", a), 1, 32'h0);
            drain();
        end
        rd_addr = {5'd21, 5'd31};
        #1;
        expect_v("post_flush_nb_r31", 4, 32'h0);
        drain();

        // Reset in the middle of a flush.
        step();
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_be   = 4'hF;
        wr_data = 32'h3131_3131;
        rsv_en  = 1'b1;
        rsv_addr = 5'd30;
        step();
        idle_inputs();
        rd_addr = {5'd30, 5'd31};
        #1;
        expect_v("pre_rst_r31", 0, 32'h3131_3131);
        expect_v("pre_rst_b30", 3, 32'h1);
        drain();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) step();
        expect_v("rst_mid_busy_before", 6, 32'h1);
        drain();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        expect_v("rst_mid_clr_busy", 6, 32'h0);
        expect_v("rst_mid_r31", 0, 32'h0);
        expect_v("rst_mid_b30", 3, 32'h0);
        drain();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        expect_v("reflush_rise", 6, 32'h1);
        drain();
        cycles = 0;
        while (clr_busy === 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        check("reflush_len", 32'(cycles - 1 + 1), 32'd32);

        $display("Result: errors=%0d of %0d checks", errs, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the single-cycle MIPS datapath, succeeding the fixed 32x32, 2-read, 1-write file. It adds configurable width, depth and read-port count, optional same-cycle write-to-read bypass, per-register byte enables, a pending-result scoreboard for multi-cycle units, and a sequenced flush. It sits between decode (read ports) and writeback (write port), with the multi-cycle unit driving the reservation port.

## Interface
- DATA_W, 32, register width in bits; multiple of 8.
- NUM_REGS, 32, register count; power of two, ≥ 4.
- NUM_RD, 2, number of read ports, 1–4.
- BYPASS, 1, 1 = same-cycle write forwards to reads; 0 = reads return stored value.
- ZERO_REG, 1, 1 = register 0 hardwired to zero.
- AW, derived: $clog2(NUM_REGS).

Ports. Reset rst_n is synchronous, active-low; clock is clk.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rd_addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational
- rd_busy  out  NUM_RD  scoreboard pending bit for each read address
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_be  in  DATA_W/8  byte enables
- wr_data  in  DATA_W  write data
- rsv_en  in  1  mark rsv_addr pending; result arrives later on the write port
- rsv_addr  in  AW  register to reserve
- clr_req  in  1  start flush; single-cycle pulse
- clr_busy  out  1  flush in progress

## Operation
- Reset: all registers, all scoreboard bits and the FSM cleared in one cycle. rd_data = 0, rd_busy = 0, clr_busy = 0.
- Write: on a clk edge with wr_en, bytes of regs[wr_addr] whose wr_be bit is set take wr_data. All other bytes are held. The write also clears pend[wr_addr].
- Reservation: on a clk edge with rsv_en, pend[rsv_addr] is set to 1.
  - Same address as a simultaneous write: the reservation wins and pend ends at 1. The write still updates data.
- ZERO_REG = 1: writes and reservations to address 0 are dropped. Reads of address 0 return 0 with busy = 0, including under bypass.
- Read port k:
  - rd_data = regs[rd_addr_k].
  - If BYPASS and wr_en and wr_addr == rd_addr_k (and that address is not the zero register), rd_data is the byte-merged value: wr_data on enabled bytes, stored bytes elsewhere.
  - rd_busy_k = pend[rd_addr_k], forced to 0 when a bypassing write hits that port in the same cycle.
- Flush FSM:
  - IDLE: on clr_req go to CLEAR with cnt = 0.
  - CLEAR: each cycle zero regs[cnt] and pend[cnt], then increment cnt. Return to IDLE after cnt = NUM_REGS-1.
  - clr_busy = 1 whenever the FSM is in CLEAR.
  - During CLEAR, wr_en, rsv_en and clr_req are ignored. Reads stay live and return current contents.

## Timing
- Reads and rd_busy are zero-latency combinational. A write is visible in storage on the cycle after the edge, or in the same cycle via bypass.
- Flush takes exactly NUM_REGS cycles. clr_busy rises on the edge after clr_req and falls on the edge after the last entry is cleared.
- rst_n low mid-flush: FSM returns to IDLE and storage is zero on the next edge.
- cnt wraps naturally at NUM_REGS; no counter state outside CLEAR.

## Structure
- Package regfile_pkg holds:
  - the flush FSM state enum (IDLE, CLEAR);
  - the localparam helper for AW;
  - the byte-merge function shared by write and bypass paths.
- Sub-module reg_scoreboard (NUM_REGS pending bits, set/clear priority, zero-register masking, NUM_RD lookup ports) is natural. Storage, bypass muxing and the flush FSM stay in reg_file_mp.

## Test plan
- Reset, then write r5 = 0xDEADBEEF with wr_be = 4'hF. Next cycle rd_addr0 = 5 → rd_data0 = 0xDEADBEEF. r0 write of 0x1234 → reads 0.
- BYPASS = 1: r7 holds 0x11223344. Same cycle, write r7 be = 4'b0011, data 0xAABBCCDD, and read r7 → rd_data = 0x1122CCDD. With BYPASS = 0 → 0x11223344.
- rsv r9, then two idle cycles: rd_busy = 1. Write r9 = 0x55 → same cycle rd_busy = 0 (bypass), next cycle pend cleared.
- Simultaneous rsv_en and wr_en to r3 → pend[3] = 1 after the edge, r3 data updated.
- Fill all registers, pulse clr_req. clr_busy is high for 32 cycles. A write attempted mid-flush leaves that register at 0. All reads are 0 after flush.
- Assert rst_n = 0 at flush cycle 10 → clr_busy = 0 next cycle, all registers 0, a new clr_req is accepted.
